// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep controller: opcodes, payload
// layout, sweep configuration record and FSM state encodings.
package dds_pkg;

    localparam logic [7:0] CMD_TONE  = 8'hFD;
    localparam logic [7:0] CMD_SWEEP = 8'hFE;

    localparam int SWEEP_PAYLOAD_LEN = 14;
    localparam int SWEEP_DWELL_W     = 24;

    localparam int OFF_MODE  = 0;
    localparam int OFF_START = 1;
    localparam int OFF_STEP  = 5;
    localparam int OFF_COUNT = 9;
    localparam int OFF_DWELL = 11;

    localparam int MODE_EN_BIT   = 0;
    localparam int MODE_RPT_BIT  = 1;
    localparam int MODE_DOWN_BIT = 2;

    typedef struct packed {
        logic [31:0]              start_word;
        logic [31:0]              step_word;
        logic [15:0]              count;
        logic [SWEEP_DWELL_W-1:0] dwell;
        logic                     rpt;
        logic                     down;
    } sweep_cfg_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RECV,
        R_APPLY
    } rx_state_t;

    typedef enum logic {
        S_IDLE,
        S_DWELL
    } sw_state_t;

endpackage

// File: rtl/dds_sweep_engine.sv
// Sweep engine: steps the DDS frequency word through one or more passes,
// holding each value for the configured dwell and strobing every new word.
module dds_sweep_engine
    import dds_pkg::*;
#(
    parameter logic [31:0] DEFAULT_FREQ = 32'd21474836,
    parameter int          DWELL_W      = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apply_i,
    input  logic        enable_i,
    input  sweep_cfg_t  cfg_i,
    output logic [31:0] fre_word_o,
    output logic        fre_update_o,
    output logic        sweep_active_o,
    output logic        sweep_done_o
);

    sw_state_t            state_q, state_d;
    sweep_cfg_t           cfg_q, cfg_d;
    logic [31:0]          fre_word_q, fre_word_d;
    logic                 fre_update_q, fre_update_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic [15:0]          step_idx_q, step_idx_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [SWEEP_DWELL_W-1:0] dwell_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            fre_word_q   <= DEFAULT_FREQ;
            fre_update_q <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            step_idx_q   <= '0;
            dwell_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            fre_word_q   <= fre_word_d;
            fre_update_q <= fre_update_d;
            active_q     <= active_d;
            done_q       <= done_d;
            step_idx_q   <= step_idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        fre_word_d   = fre_word_q;
        fre_update_d = 1'b0;
        active_d     = active_q;
        done_d       = 1'b0;
        step_idx_d   = step_idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        // A zero dwell would stall the counter reload, so it runs as one cycle.
        dwell_ld     = (cfg_i.dwell == '0) ? SWEEP_DWELL_W'(1) : cfg_i.dwell;

        if (apply_i) begin
            if (enable_i) begin
                cfg_d        = cfg_i;
                cfg_d.dwell  = dwell_ld;
                fre_word_d   = cfg_i.start_word;
                fre_update_d = 1'b1;
                step_idx_d   = '0;
                dwell_cnt_d  = DWELL_W'(dwell_ld - SWEEP_DWELL_W'(1));
                active_d     = 1'b1;
                state_d      = S_DWELL;
            end else begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
        end else if (state_q == S_DWELL) begin
            if (dwell_cnt_q != '0) begin
                dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            end else if (step_idx_q != cfg_q.count) begin
                fre_word_d   = cfg_q.down ? (fre_word_q - cfg_q.step_word)
                                          : (fre_word_q + cfg_q.step_word);
                step_idx_d   = step_idx_q + 16'd1;
                dwell_cnt_d  = DWELL_W'(cfg_q.dwell - SWEEP_DWELL_W'(1));
                fre_update_d = 1'b1;
            end else begin
                done_d = 1'b1;
                if (cfg_q.rpt) begin
                    fre_word_d   = cfg_q.start_word;
                    fre_update_d = 1'b1;
                    step_idx_d   = '0;
                    dwell_cnt_d  = DWELL_W'(cfg_q.dwell - SWEEP_DWELL_W'(1));
                end else begin
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
        end
    end

    assign fre_word_o     = fre_word_q;
    assign fre_update_o   = fre_update_q;
    assign sweep_active_o = active_q;
    assign sweep_done_o   = done_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Command-bus front end for the sweep engine: receives the sweep packet into a
// payload buffer and hands the decoded configuration over on completion.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter logic [7:0]  CMD_TYPE     = CMD_SWEEP,
    parameter int          PAYLOAD_LEN  = SWEEP_PAYLOAD_LEN,
    parameter logic [31:0] DEFAULT_FREQ = 32'd21474836,
    parameter int          DWELL_W      = SWEEP_DWELL_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_type,
    input  logic [15:0] cmd_length,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_data_index,
    input  logic        cmd_start,
    input  logic        cmd_data_valid,
    input  logic        cmd_done,
    output logic        cmd_ready,
    output logic [31:0] fre_word,
    output logic        fre_update,
    output logic        sweep_active,
    output logic        sweep_done
);

    rx_state_t              rstate_q, rstate_d;
    logic                   cmd_ready_q;
    logic [7:0]             payload_q [PAYLOAD_LEN];
    logic [PAYLOAD_LEN-1:0] byte_we;
    logic                   wr_en;
    logic                   apply;
    sweep_cfg_t             sweep_cfg;
    logic                   unused_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q    <= R_IDLE;
            cmd_ready_q <= 1'b1;
        end else begin
            rstate_q    <= rstate_d;
            cmd_ready_q <= (rstate_d != R_APPLY);
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (cmd_start && (cmd_type == CMD_TYPE)) rstate_d = R_RECV;
            R_RECV:  if (cmd_done) rstate_d = R_APPLY;
            R_APPLY: rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // A byte arriving together with cmd_done is still in R_RECV, so it lands.
    assign wr_en = (rstate_q == R_RECV) && cmd_data_valid
                   && (cmd_data_index < 16'(PAYLOAD_LEN));

    for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_byte_we
        assign byte_we[gi] = wr_en && (cmd_data_index == 16'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAYLOAD_LEN; i++) payload_q[i] <= '0;
        end else begin
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                if (byte_we[i]) payload_q[i] <= cmd_data;
            end
        end
    end

    always_comb begin
        sweep_cfg.start_word = {payload_q[OFF_START], payload_q[OFF_START+1],
                                payload_q[OFF_START+2], payload_q[OFF_START+3]};
        sweep_cfg.step_word  = {payload_q[OFF_STEP], payload_q[OFF_STEP+1],
                                payload_q[OFF_STEP+2], payload_q[OFF_STEP+3]};
        sweep_cfg.count      = {payload_q[OFF_COUNT], payload_q[OFF_COUNT+1]};
        sweep_cfg.dwell      = {payload_q[OFF_DWELL], payload_q[OFF_DWELL+1],
                                payload_q[OFF_DWELL+2]};
        sweep_cfg.rpt        = payload_q[OFF_MODE][MODE_RPT_BIT];
        sweep_cfg.down       = payload_q[OFF_MODE][MODE_DOWN_BIT];
    end

    assign apply     = (rstate_q == R_APPLY);
    assign cmd_ready = cmd_ready_q;
    assign unused_ok = ^{cmd_length, payload_q[OFF_MODE][7:3]};

    dds_sweep_engine #(
        .DEFAULT_FREQ (DEFAULT_FREQ),
        .DWELL_W      (DWELL_W)
    ) u_engine (
        .clk            (clk),
        .rst_n          (rst_n),
        .apply_i        (apply),
        .enable_i       (payload_q[OFF_MODE][MODE_EN_BIT]),
        .cfg_i          (sweep_cfg),
        .fre_word_o     (fre_word),
        .fre_update_o   (fre_update),
        .sweep_active_o (sweep_active),
        .sweep_done_o   (sweep_done)
    );

endmodule
